// File: rtl/buf_level_tracker_if.sv
// ============================================================================
// Module   : buf_level_tracker_if
// Brief    : Request/status bundle between a buffer controller and the
//            per-channel occupancy tracker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface buf_level_tracker_if #(
    parameter int CH    = 4,
    parameter int DEPTH = 6,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    localparam int MAX_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]       push;
    logic [CH-1:0]       pop;
    logic                load;
    logic [CH*DEPTH-1:0] valid_vec;
    logic                err_clr;
    logic [CH*CNT_W-1:0] level;
    logic [CH-1:0]       full;
    logic [CH-1:0]       empty;
    logic [CH-1:0]       ovf;
    logic [CH-1:0]       udf;
    logic [MAX_W-1:0]    max_ch;
    logic [CNT_W-1:0]    max_level;

    modport master (
        output push, pop, load, valid_vec, err_clr,
        input  level, full, empty, ovf, udf, max_ch, max_level
    );

    modport slave (
        input  push, pop, load, valid_vec, err_clr,
        output level, full, empty, ovf, udf, max_ch, max_level
    );
endinterface

`default_nettype wire

// File: rtl/buf_level_tracker.sv
// ============================================================================
// Module   : buf_level_tracker
// Brief    : Per-channel saturating buffer occupancy counters with sticky
//            overflow/underflow flags and load-from-valid-bits resync.
//            Optional highest-level selector enabled by BUF_LEVEL_MAXSEL_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module buf_level_tracker #(
    parameter int CH    = 4,
    parameter int DEPTH = 6,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    buf_level_tracker_if.slave  bus
);
    localparam int               MAX_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [CH*CNT_W-1:0] w_level_vec;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CNT_W-1:0] w_pop_cnt;
        logic [CNT_W-1:0] w_next;
        logic             w_ovf_ev;
        logic             w_udf_ev;
        logic [CNT_W-1:0] r_level;
        logic             r_full;
        logic             r_empty;
        logic             r_ovf;
        logic             r_udf;

        // Popcount stays within CNT_W since it never exceeds DEPTH.
        always_comb begin
            w_pop_cnt = '0;
            for (int e = 0; e < DEPTH; e++) begin
                w_pop_cnt = w_pop_cnt + CNT_W'(bus.valid_vec[c*DEPTH + e]);
            end
        end

        always_comb begin
            w_next   = r_level;
            w_ovf_ev = 1'b0;
            w_udf_ev = 1'b0;
            if (bus.load) begin
                w_next = w_pop_cnt;
            end else if (bus.push[c] && !bus.pop[c]) begin
                if (r_level == C_DEPTH) w_ovf_ev = 1'b1;
                else                    w_next   = r_level + CNT_W'(1);
            end else if (bus.pop[c] && !bus.push[c]) begin
                if (r_level == '0) w_udf_ev = 1'b1;
                else               w_next   = r_level - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_level <= '0;
                r_full  <= 1'b0;
                r_empty <= 1'b1;
                r_ovf   <= 1'b0;
                r_udf   <= 1'b0;
            end else begin
                r_level <= w_next;
                r_full  <= (w_next == C_DEPTH);
                r_empty <= (w_next == '0);
                // Clear wins over a same-cycle error event.
                r_ovf   <= !bus.err_clr && (r_ovf || w_ovf_ev);
                r_udf   <= !bus.err_clr && (r_udf || w_udf_ev);
            end
        end

        assign w_level_vec[c*CNT_W +: CNT_W] = r_level;
        assign bus.level[c*CNT_W +: CNT_W]   = r_level;
        assign bus.full[c]                   = r_full;
        assign bus.empty[c]                  = r_empty;
        assign bus.ovf[c]                    = r_ovf;
        assign bus.udf[c]                    = r_udf;
    end

`ifdef BUF_LEVEL_MAXSEL_EN
    logic [MAX_W-1:0] w_max_ch;
    logic [CNT_W-1:0] w_max_lvl;
    logic [MAX_W-1:0] r_max_ch;
    logic [CNT_W-1:0] r_max_lvl;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_max_ch  = '0;
        w_max_lvl = '0;
        for (int c = 0; c < CH; c++) begin
            if (w_level_vec[c*CNT_W +: CNT_W] > w_max_lvl) begin
                w_max_lvl = w_level_vec[c*CNT_W +: CNT_W];
                w_max_ch  = MAX_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_max_ch  <= '0;
            r_max_lvl <= '0;
        end else begin
            r_max_ch  <= w_max_ch;
            r_max_lvl <= w_max_lvl;
        end
    end

    assign bus.max_ch    = r_max_ch;
    assign bus.max_level = r_max_lvl;
`else
    logic w_unused_levels;
    assign w_unused_levels = ^w_level_vec;
    assign bus.max_ch      = '0;
    assign bus.max_level   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_buf_level_tracker.sv
// ============================================================================
// Module   : tb_buf_level_tracker
// Brief    : Directed self-checking bench for buf_level_tracker (CH=4, DEPTH=6).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_buf_level_tracker;
    localparam int CH    = 4;
    localparam int DEPTH = 6;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_chk;

    buf_level_tracker_if #(.CH(CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    buf_level_tracker #(.CH(CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [CNT_W-1:0] lvl(input int c);
        return bus.level[c*CNT_W +: CNT_W];
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},     64'(bus.level),     64'h0);
        check({tag, "_empty"},     64'(bus.empty),     64'hF);
        check({tag, "_full"},      64'(bus.full),      64'h0);
        check({tag, "_ovf"},       64'(bus.ovf),       64'h0);
        check({tag, "_udf"},       64'(bus.udf),       64'h0);
        check({tag, "_max_ch"},    64'(bus.max_ch),    64'h0);
        check({tag, "_max_level"}, 64'(bus.max_level), 64'h0);
    endtask

    initial begin
        n_pass        = 0;
        n_chk         = 0;
        rst_n         = 1'b0;
        bus.push      = '0;
        bus.pop       = '0;
        bus.load      = 1'b0;
        bus.valid_vec = '0;
        bus.err_clr   = 1'b0;

        // Reset state
        step();
        step();
        check_reset_state("reset");

        // Push channel 0 seven times: 1..6 then saturate with overflow
        rst_n    = 1'b1;
        bus.push = 4'b0001;
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("push0_lvl_%0d", i), 64'(lvl(0)), 64'((i < 6) ? i : 6));
            check($sformatf("push0_full_%0d", i), 64'(bus.full[0]), 64'(i >= 6));
        end
        check("push0_ovf", 64'(bus.ovf), 64'h1);
        check("push0_udf", 64'(bus.udf), 64'h0);
        bus.push = '0;

        // Underflow on channel 2, then clear (also clears ch0 overflow)
        bus.pop = 4'b0100;
        step();
        check("pop2_lvl",   64'(lvl(2)),   64'h0);
        check("pop2_udf",   64'(bus.udf),  64'h4);
        check("pop2_empty", 64'(bus.empty), 64'hE);
        bus.pop     = '0;
        bus.err_clr = 1'b1;
        step();
        check("clr_udf", 64'(bus.udf), 64'h0);
        check("clr_ovf", 64'(bus.ovf), 64'h0);
        bus.err_clr = 1'b0;

        // Pass-through at level 0 on channel 1
        bus.push = 4'b0010;
        bus.pop  = 4'b0010;
        step();
        check("pt0_lvl", 64'(lvl(1)),  64'h0);
        check("pt0_ovf", 64'(bus.ovf), 64'h0);
        check("pt0_udf", 64'(bus.udf), 64'h0);

        // Fill channel 1 then pass-through at DEPTH
        bus.pop = '0;
        repeat (6) step();
        check("fill1_lvl",  64'(lvl(1)),   64'h6);
        check("fill1_full", 64'(bus.full), 64'h3);
        bus.pop = 4'b0010;
        step();
        check("pt6_lvl", 64'(lvl(1)),  64'h6);
        check("pt6_ovf", 64'(bus.ovf), 64'h0);
        check("pt6_udf", 64'(bus.udf), 64'h0);
`ifdef BUF_LEVEL_MAXSEL_EN
        check("tie_max_ch",    64'(bus.max_ch),    64'h0);
        check("tie_max_level", 64'(bus.max_level), 64'h6);
`else
        check("tie_max_ch",    64'(bus.max_ch),    64'h0);
        check("tie_max_level", 64'(bus.max_level), 64'h0);
`endif
        bus.push = '0;
        bus.pop  = '0;

        // Load with channel 3 = 101101 and pushes that must be ignored
        bus.load      = 1'b1;
        bus.push      = 4'b1001;
        bus.valid_vec = {6'b101101, 6'b000000, 6'b000000, 6'b000000};
        step();
        check("load_level", 64'(bus.level), 64'h800);
        check("load_empty", 64'(bus.empty), 64'h7);
        check("load_full",  64'(bus.full),  64'h0);
        check("load_ovf",   64'(bus.ovf),   64'h0);

        // Load levels {2,5,5,1}
        bus.push      = '0;
        bus.valid_vec = {6'b000100, 6'b111110, 6'b011111, 6'b000011};
        step();
        check("load2_level", 64'(bus.level), 64'({3'd1, 3'd5, 3'd5, 3'd2}));
        bus.load = 1'b0;
        step();
        check("hold_level", 64'(bus.level), 64'({3'd1, 3'd5, 3'd5, 3'd2}));
`ifdef BUF_LEVEL_MAXSEL_EN
        check("max_ch",    64'(bus.max_ch),    64'h1);
        check("max_level", 64'(bus.max_level), 64'h5);
`else
        check("max_ch",    64'(bus.max_ch),    64'h0);
        check("max_level", 64'(bus.max_level), 64'h0);
`endif

        // Clear priority over a same-cycle underflow; load acts alongside
        bus.valid_vec = '0;
        bus.load      = 1'b1;
        step();
        bus.load    = 1'b0;
        bus.pop     = 4'b0001;
        bus.err_clr = 1'b1;
        step();
        check("clrpri_udf", 64'(bus.udf),   64'h0);
        check("clrpri_lvl", 64'(bus.level), 64'h0);
        bus.err_clr = 1'b0;
        step();
        check("udf_again", 64'(bus.udf), 64'h1);
        bus.pop = '0;

        // Reset mid-operation with push and load active
        bus.push      = 4'hF;
        bus.load      = 1'b1;
        bus.valid_vec = '1;
        rst_n         = 1'b0;
        step();
        check_reset_state("midrst");
        rst_n    = 1'b1;
        bus.push = '0;
        bus.load = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
